// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types and constants for the mycpu pipeline.
//   fetch_state_t : state encoding of the instruction fetch FSM.
//   PC_W          : program counter / instruction memory address width.
//   pc_add        : modulo-2^PC_W addition used for PC-relative branches.
package mycpu_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_LOAD = 2'd2
  } fetch_state_t;

  // Branch target: the offset is two's complement, so a plain wrapping add
  // covers both forward and backward branches.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                             input logic [PC_W-1:0] offset);
    return pc + offset;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of mycpu, directly upstream of the IR.
// Owns the PC, reads instruction memory over a req/ack handshake and hands
// each fetched word to the IR with a one-cycle load strobe.
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   fetch_req             start one fetch (honoured in IDLE only)
//   pc_branch, ia_in      PC <= PC + ia_in (honoured in IDLE only)
//   imem_req, imem_addr   memory read request and word address (= PC)
//   imem_ack, imem_rdata  memory response, data valid when ack=1
//   ins_out, il_out       fetched word and load strobe to the IR
//   fetch_done            one-cycle pulse, coincident with il_out
//   fetch_err             one-cycle pulse when a fetch times out
//   pc_out                current (registered) PC
module fetch_unit
  import mycpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC       = 16'h0000,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req,
  input  logic            pc_branch,
  input  logic [PC_W-1:0] ia_in,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] ins_out,
  output logic            il_out,
  output logic            fetch_done,
  output logic            fetch_err,
  output logic [PC_W-1:0] pc_out
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  fetch_state_t     state_r;
  fetch_state_t     state_next_s;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  ins_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  logic             timeout_s;

  // Last permitted WAIT cycle passed without an ack; an ack in that same
  // cycle takes priority, so it suppresses the timeout.
  assign timeout_s = (state_r == FETCH_WAIT) && !imem_ack && (cnt_r == CNT_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; a branch in IDLE drops a simultaneous fetch_req.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH_IDLE: begin
        if (pc_branch) begin
          state_next_s = FETCH_IDLE;
        end else if (fetch_req) begin
          state_next_s = FETCH_WAIT;
        end else begin
          state_next_s = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (imem_ack) begin
          state_next_s = FETCH_LOAD;
        end else if (timeout_s) begin
          state_next_s = FETCH_IDLE;
        end else begin
          state_next_s = FETCH_WAIT;
        end
      end
      FETCH_LOAD: state_next_s = FETCH_IDLE;
      default:    state_next_s = FETCH_IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    imem_req   = 1'b0;
    il_out     = 1'b0;
    fetch_done = 1'b0;
    case (state_r)
      FETCH_IDLE: begin
        imem_req   = 1'b0;
        il_out     = 1'b0;
        fetch_done = 1'b0;
      end
      FETCH_WAIT: imem_req = 1'b1;
      FETCH_LOAD: begin
        il_out     = 1'b1;
        fetch_done = 1'b1;
      end
      default: begin
        imem_req   = 1'b0;
        il_out     = 1'b0;
        fetch_done = 1'b0;
      end
    endcase
  end

  // PC: relative branch in IDLE, post-increment on the LOAD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if ((state_r == FETCH_IDLE) && pc_branch) begin
      pc_r <= pc_add(pc_r, ia_in);
    end else if (state_r == FETCH_LOAD) begin
      pc_r <= pc_r + 16'd1;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction capture; holds between fetches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_r <= 16'h0000;
    end else if ((state_r == FETCH_WAIT) && imem_ack) begin
      ins_r <= imem_rdata;
    end else begin
      ins_r <= ins_r;
    end
  end

  // Timeout counter: counts WAIT cycles, cleared whenever not waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if ((state_r == FETCH_WAIT) && !imem_ack && !timeout_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= '0;
    end
  end

  // Registered one-cycle error pulse, lands in the IDLE cycle after the abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
    end
  end

  assign imem_addr = pc_r;
  assign pc_out    = pc_r;
  assign ins_out   = ins_r;
  assign fetch_err = err_r;

endmodule
